bus_xfer_ctrl: RTL and testbench
================================

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1, giving the number of cycles (1..15) the source is driven before the destination load.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port clear, input, 1, reset; asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 1, transfer request, sampled only in IDLE.
REQ-005 The block SHALL have port src_sel, input, 5, source register code; R0=0, R1=1, MDR=2.
REQ-006 The block SHALL have port dst_sel, input, 5, destination register code; same coding as src_sel.
REQ-007 The block SHALL have port drive_out, output, 32, one-hot bus drive enables that feed the bus select-encoder input.
REQ-008 The block SHALL have port load_in, output, 32, one-hot register load enables.
REQ-009 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 The block SHALL have port done, output, 1, one-cycle pulse when a transfer completes.
REQ-011 The block SHALL have port err, output, 1, one-cycle pulse when a request is rejected.
REQ-012 The block SHALL have port xfer_count, output, 16, count of completed transfers.

Function
REQ-013 The FSM SHALL have the states IDLE, DRIVE, LOAD, DONE and ERR.
REQ-014 In IDLE with req=1 and both codes <= 2, the block SHALL latch src_sel and dst_sel on the clock edge and enter DRIVE.
REQ-015 In IDLE with req=1 and either code > 2, the block SHALL enter ERR without latching either code.
REQ-016 ERR SHALL last one cycle with err=1 and drive_out=0 and load_in=0, then return to IDLE.
REQ-017 DRIVE SHALL last exactly SETTLE_CYCLES cycles, using an internal 4-bit counter.
REQ-018 During DRIVE, drive_out SHALL equal (1 << latched src) and load_in SHALL be 0.
REQ-019 LOAD SHALL last one cycle, with drive_out still equal to (1 << src) and load_in equal to (1 << dst).
REQ-020 DONE SHALL last one cycle with done=1, drive_out=0 and load_in=0; xfer_count SHALL increment by 1 and wrap from 0xFFFF to 0x0000; the FSM then returns to IDLE.
REQ-021 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-022 Latency from the edge that samples req to the first cycle of done SHALL be SETTLE_CYCLES+1 cycles; the next request is accepted in the cycle after DONE.
REQ-023 A transfer with src equal to dst SHALL be legal and run the normal sequence.
REQ-024 req, src_sel and dst_sel changes outside IDLE SHALL be ignored; the latched codes are used for the whole transfer.
REQ-025 drive_out and load_in SHALL each have at most one bit set in every cycle, and drive_out=0 outside DRIVE and LOAD.
REQ-026 done and err SHALL never be high in the same cycle.

Reset
REQ-027 clear=0 SHALL force, without waiting for a clock edge: IDLE, drive_out=0, load_in=0, busy=0, done=0, err=0, xfer_count=0, settle counter=0.
REQ-028 Asserting clear during DRIVE or LOAD SHALL abort the transfer; no load_in pulse and no done may follow it.
REQ-029 After clear is released, the first rising edge SHALL behave as IDLE sampling req.

Structure
REQ-030 The shared package SHALL hold the state enum, the register codes CODE_R0=0, CODE_R1=1 and CODE_MDR=2, and NUM_BUS_SRC=3.
REQ-031 One sub-module sel_decoder SHALL perform the 5-bit code to 32-bit one-hot decode; it SHALL be instantiated twice, once for drive_out and once for load_in.
REQ-032 sel_decoder SHALL output 0 for an enable of 0 and for codes > 2.

Verification
REQ-033 Scenario: SETTLE_CYCLES=1, req with src=1 and dst=0 -> drive_out=0x2 for 2 cycles; load_in=0x1 in the second of them; done in the next cycle; xfer_count=1.
REQ-034 Scenario: req with src=2 and dst=2 -> drive_out=0x4 and load_in=0x4 in LOAD; done pulses once.
REQ-035 Scenario: req with src=5 and dst=0 -> one err pulse; drive_out and load_in stay 0; xfer_count unchanged.
REQ-036 Scenario: SETTLE_CYCLES=3, src=0 and dst=1, with src_sel changed to 2 mid-DRIVE -> drive_out=0x1 for 4 cycles; load_in=0x2 on the 4th; done on the 5th.
REQ-037 Scenario: clear pulsed low during LOAD -> all outputs go to 0 at once; no done; the next req completes normally.
REQ-038 Scenario: 65536 back-to-back transfers -> xfer_count returns to 0x0000; one-hot checks hold throughout.

Source files
------------

// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared types and register codes for the register-to-register bus transfer controller.
// Everything here is used by both the controller and its select decoder.
package bus_xfer_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam int CODE_W      = 5;
    localparam int ONEHOT_W    = 32;
    localparam int COUNT_W     = 16;
    localparam int SETTLE_W    = 4;
    localparam int NUM_BUS_SRC = 3;

    localparam logic [CODE_W-1:0] CODE_R0  = 5'd0;
    localparam logic [CODE_W-1:0] CODE_R1  = 5'd1;
    localparam logic [CODE_W-1:0] CODE_MDR = 5'd2;

    // Only R0, R1 and MDR exist on the bus; every other code is rejected.
    function automatic logic code_valid(input logic [CODE_W-1:0] code);
        return code <= CODE_MDR;
    endfunction

endpackage

// File: rtl/bus_xfer_ctrl_sel_decoder.sv
// Register code to one-hot enable decoder; unknown codes and a low enable give all zeros.
module sel_decoder
    import bus_xfer_ctrl_pkg::*;
(
    input  logic                en,
    input  logic [CODE_W-1:0]   code,
    output logic [ONEHOT_W-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en && code_valid(code)) begin
            onehot[code] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Sequences a bus transfer: drive the source for SETTLE_CYCLES, load the destination, report done.
// All outputs come straight from flops fed by the next-state decode.
module bus_xfer_ctrl
    import bus_xfer_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                req,
    input  logic [CODE_W-1:0]   src_sel,
    input  logic [CODE_W-1:0]   dst_sel,
    output logic [ONEHOT_W-1:0] drive_out,
    output logic [ONEHOT_W-1:0] load_in,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [COUNT_W-1:0]  xfer_count
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t                state;
    state_t                state_nxt;
    logic [CODE_W-1:0]     src_q;
    logic [CODE_W-1:0]     dst_q;
    logic [CODE_W-1:0]     src_nxt;
    logic [CODE_W-1:0]     dst_nxt;
    logic [SETTLE_W-1:0]   settle_cnt;
    logic [SETTLE_W-1:0]   settle_nxt;
    logic                  drive_en;
    logic                  load_en;
    logic [ONEHOT_W-1:0]   drive_nxt;
    logic [ONEHOT_W-1:0]   load_nxt;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state      <= ST_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            settle_cnt <= '0;
            drive_out  <= '0;
            load_in    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            xfer_count <= '0;
        end else begin
            state      <= state_nxt;
            src_q      <= src_nxt;
            dst_q      <= dst_nxt;
            settle_cnt <= settle_nxt;
            drive_out  <= drive_nxt;
            load_in    <= load_nxt;
            busy       <= (state_nxt != ST_IDLE);
            done       <= (state_nxt == ST_DONE);
            err        <= (state_nxt == ST_ERR);
            if (state_nxt == ST_DONE) begin
                xfer_count <= xfer_count + 16'd1;
            end
        end
    end

    // Codes are captured only when a legal request is accepted in IDLE.
    always_comb begin
        state_nxt  = state;
        src_nxt    = src_q;
        dst_nxt    = dst_q;
        settle_nxt = settle_cnt;
        case (state)
            ST_IDLE: begin
                settle_nxt = '0;
                if (req) begin
                    if (code_valid(src_sel) && code_valid(dst_sel)) begin
                        state_nxt = ST_DRIVE;
                        src_nxt   = src_sel;
                        dst_nxt   = dst_sel;
                    end else begin
                        state_nxt = ST_ERR;
                    end
                end
            end
            ST_DRIVE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt  = ST_LOAD;
                    settle_nxt = '0;
                end else begin
                    settle_nxt = settle_cnt + 4'd1;
                end
            end
            ST_LOAD:  state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            ST_ERR:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Enables are decoded from the upcoming state so the output flops line up with it.
    always_comb begin
        drive_en = (state_nxt == ST_DRIVE) || (state_nxt == ST_LOAD);
        load_en  = (state_nxt == ST_LOAD);
    end

    sel_decoder u_drive_dec (
        .en     (drive_en),
        .code   (src_nxt),
        .onehot (drive_nxt)
    );

    sel_decoder u_load_dec (
        .en     (load_en),
        .code   (dst_nxt),
        .onehot (load_nxt)
    );

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Scoreboard bench for bus_xfer_ctrl: two instances (settle 1 and settle 3) driven by directed vectors.
module tb_bus_xfer_ctrl;

    typedef struct packed {
        logic        is_err;
        logic [31:0] drv;
        logic [31:0] ld;
        logic [15:0] cnt;
    } exp_t;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [4:0]  src0 = '0, dst0 = '0, src1 = '0, dst1 = '0;
    logic [31:0] drive0, load0, drive1, load1;
    logic        busy0, done0, err0, busy1, done1, err1;
    logic [15:0] cnt0, cnt1;

    int          tests = 0;
    int          fails = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] model_cnt[2] = '{16'd0, 16'd0};
    int          settle_of[2] = '{1, 3};
    int          drv_cyc[2]   = '{0, 0};
    int          ld_cyc[2]    = '{0, 0};
    bit          prev_ld[2]   = '{1'b0, 1'b0};

    bus_xfer_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clock(clock), .clear(clear), .req(req0), .src_sel(src0), .dst_sel(dst0),
        .drive_out(drive0), .load_in(load0), .busy(busy0), .done(done0), .err(err0),
        .xfer_count(cnt0)
    );

    bus_xfer_ctrl #(.SETTLE_CYCLES(3)) u_dut3 (
        .clock(clock), .clear(clear), .req(req1), .src_sel(src1), .dst_sel(dst1),
        .drive_out(drive1), .load_in(load1), .busy(busy1), .done(done1), .err(err1),
        .xfer_count(cnt1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req_v);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req_v, $time);
        end
    endtask

    task automatic pop(input int id);
        if (id == 0) void'(q0.pop_front());
        else         void'(q1.pop_front());
        drv_cyc[id] = 0;
        ld_cyc[id]  = 0;
    endtask

    task automatic mon(input int id, input logic [31:0] d, input logic [31:0] l, input logic bsy,
                       input logic dn, input logic er, input logic [15:0] cnt);
        exp_t  e;
        bit    have;
        string p;
        e = '0;
        have = 1'b0;
        p = $sformatf("dut%0d", id);
        if (id == 0 && q0.size() > 0) begin have = 1'b1; e = q0[0]; end
        if (id == 1 && q1.size() > 0) begin have = 1'b1; e = q1[0]; end
        chk({p, "_onehot_drive"}, $onehot0(d), d, 32'h0);
        chk({p, "_onehot_load"}, $onehot0(l), l, 32'h0);
        chk({p, "_done_err_excl"}, !(dn && er), {30'h0, dn, er}, 32'h0);
        if (!bsy) begin
            chk({p, "_idle_outputs"}, d == 0 && l == 0 && !dn && !er, d | l, 32'h0);
            chk({p, "_idle_count"}, cnt == model_cnt[id], cnt, model_cnt[id]);
        end
        if (d != 0) begin
            drv_cyc[id]++;
            chk({p, "_drive_sel"}, have && !e.is_err && d == e.drv, d, e.drv);
        end
        if (l != 0) begin
            ld_cyc[id]++;
            chk({p, "_load_sel"}, have && !e.is_err && l == e.ld, l, e.ld);
            chk({p, "_drive_in_load"}, d == e.drv, d, e.drv);
        end
        if (dn) begin
            chk({p, "_done_expected"}, have && !e.is_err, {31'h0, have}, 32'h1);
            chk({p, "_done_busy"}, bsy, {31'h0, bsy}, 32'h1);
            chk({p, "_done_outputs_zero"}, d == 0 && l == 0, d | l, 32'h0);
            chk({p, "_drive_cycles"}, drv_cyc[id] == settle_of[id] + 1, drv_cyc[id], settle_of[id] + 1);
            chk({p, "_load_cycles"}, ld_cyc[id] == 1, ld_cyc[id], 32'h1);
            chk({p, "_load_then_done"}, prev_ld[id], {31'h0, prev_ld[id]}, 32'h1);
            chk({p, "_xfer_count"}, cnt == e.cnt, cnt, e.cnt);
            if (have) pop(id);
        end
        if (er) begin
            chk({p, "_err_expected"}, have && e.is_err, {31'h0, have}, 32'h1);
            chk({p, "_err_outputs_zero"}, d == 0 && l == 0, d | l, 32'h0);
            chk({p, "_err_no_drive"}, drv_cyc[id] == 0, drv_cyc[id], 32'h0);
            chk({p, "_err_count_kept"}, cnt == e.cnt, cnt, e.cnt);
            if (have) pop(id);
        end
        prev_ld[id] = (l != 0);
    endtask

    always @(negedge clock) begin
        mon(0, drive0, load0, busy0, done0, err0, cnt0);
        mon(1, drive1, load1, busy1, done1, err1, cnt1);
    end

    task automatic set_in(input int id, input logic r, input logic [4:0] s, input logic [4:0] d);
        if (id == 0) begin req0 = r; src0 = s; dst0 = d; end
        else         begin req1 = r; src1 = s; dst1 = d; end
    endtask

    // Issue one request; after the sampling edge the codes are scrambled to ms/md.
    task automatic run(input int id, input logic [4:0] s, input logic [4:0] d, input logic [4:0] ms,
                       input logic [4:0] md, input bit ok, input logic [31:0] edrv, input logic [31:0] eld);
        exp_t e;
        set_in(id, 1'b1, s, d);
        @(posedge clock);
        #1;
        e.is_err = !ok;
        e.drv    = ok ? edrv : 32'h0;
        e.ld     = ok ? eld : 32'h0;
        if (ok) model_cnt[id] = model_cnt[id] + 16'd1;
        e.cnt    = model_cnt[id];
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
        set_in(id, 1'b0, ms, md);
        repeat (ok ? settle_of[id] + 2 : 1) @(posedge clock);
        #1;
    endtask

    task automatic flush_all();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            drv_cyc[i]   = 0;
            ld_cyc[i]    = 0;
            prev_ld[i]   = 1'b0;
            model_cnt[i] = 16'd0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_outputs", drive0 == 0 && load0 == 0 && drive1 == 0 && load1 == 0, drive0 | load0, 32'h0);
        chk("reset_flags", !busy0 && !done0 && !err0 && !busy1 && !done1 && !err1,
            {26'h0, busy0, done0, err0, busy1, done1, err1}, 32'h0);
        chk("reset_count", cnt0 == 0 && cnt1 == 0, {cnt0, cnt1}, 32'h0);
        #2 clear = 1'b1;

        //   id src dst  mid-src mid-dst ok  drive      load
        run(0, 5'd1, 5'd0, 5'd2,  5'd2,  1, 32'h2,     32'h1);
        run(0, 5'd2, 5'd2, 5'd0,  5'd1,  1, 32'h4,     32'h4);
        run(0, 5'd5, 5'd0, 5'd0,  5'd0,  0, 32'h0,     32'h0);
        run(1, 5'd0, 5'd1, 5'd2,  5'd0,  1, 32'h1,     32'h2);
        run(0, 5'd0, 5'd0, 5'd31, 5'd31, 1, 32'h1,     32'h1);
        run(0, 5'd1, 5'd2, 5'd0,  5'd0,  1, 32'h2,     32'h4);
        run(0, 5'd0, 5'd3, 5'd1,  5'd1,  0, 32'h0,     32'h0);
        run(0, 5'd31, 5'd31, 5'd0, 5'd0, 0, 32'h0,     32'h0);
        run(1, 5'd2, 5'd1, 5'd0,  5'd0,  1, 32'h4,     32'h2);
        run(1, 5'd1, 5'd1, 5'd3,  5'd3,  1, 32'h2,     32'h2);
        run(1, 5'd3, 5'd0, 5'd0,  5'd0,  0, 32'h0,     32'h0);

        // Abort a transfer with clear while it sits in LOAD.
        set_in(0, 1'b1, 5'd1, 5'd2);
        @(posedge clock);
        #1;
        model_cnt[0] = model_cnt[0] + 16'd1;
        e.is_err = 1'b0; e.drv = 32'h2; e.ld = 32'h4; e.cnt = model_cnt[0];
        q0.push_back(e);
        set_in(0, 1'b0, 5'd0, 5'd0);
        @(posedge clock);
        #1;
        chk("pre_clear_load", load0 == 32'h4 && drive0 == 32'h2, load0, 32'h4);
        #1 clear = 1'b0;
        #1;
        chk("clear_drive_load", drive0 == 0 && load0 == 0, drive0 | load0, 32'h0);
        chk("clear_flags", !busy0 && !done0 && !err0, {29'h0, busy0, done0, err0}, 32'h0);
        chk("clear_count", cnt0 == 0 && cnt1 == 0, {cnt0, cnt1}, 32'h0);
        flush_all();
        @(posedge clock);
        #3;
        chk("clear_held", drive0 == 0 && load0 == 0 && !done0 && !busy0, drive0 | load0, 32'h0);
        clear = 1'b1;
        run(0, 5'd2, 5'd0, 5'd1, 5'd1, 1, 32'h4, 32'h1);

        // Back-to-back transfers across all legal code pairs.
        for (int i = 0; i < 24; i++) begin
            run(0, 5'(i % 3), 5'((i / 3) % 3), 5'(i), 5'(31 - i), 1,
                32'h1 << (i % 3), 32'h1 << ((i / 3) % 3));
        end

        // Jump the counter near its top to observe the 16-bit wrap.
        force u_dut1.xfer_count = 16'hFFFC;
        #1 release u_dut1.xfer_count;
        model_cnt[0] = 16'hFFFC;
        for (int i = 0; i < 5; i++) begin
            run(0, 5'(i % 3), 5'((i + 2) % 3), 5'd0, 5'd0, 1,
                32'h1 << (i % 3), 32'h1 << ((i + 2) % 3));
        end
        chk("count_wrapped", cnt0 == 16'h0001, cnt0, 32'h1);

        repeat (3) @(posedge clock);
        #1;
        chk("scoreboard_drained", q0.size() == 0 && q1.size() == 0, q0.size() + q1.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
